frame_pixel_sequencer: RTL and testbench

//  Sequences one full grayscale frame out of the frame memory into the RGB pixel stream feeding the PNG path.

---
 rtl/frame_pixel_sequencer_if.sv | 40 ++++
 rtl/frame_pixel_sequencer.sv | 165 ++++++++++++++++
 tb/tb_frame_pixel_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_sequencer_if.sv
// Frame pixel sequencer bus bundle.
// Carries the frame-memory read port and the RGB pixel output stream.
//   mem_rd_en / mem_rd_addr : read strobe and linear address (driven by the sequencer)
//   mem_rd_data             : read data, valid the cycle after mem_rd_en
//   out_valid / out_ready   : output stream handshake
//   out_r/g/b               : pixel, gray replicated to all three channels
//   out_sof/eol/eof         : framing flags qualified by out_valid
// Modports: master = sequencer side, slave = memory/downstream side.
interface frame_pixel_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned PIX_W  = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_r;
  logic [PIX_W-1:0]  out_g;
  logic [PIX_W-1:0]  out_b;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    input  out_ready,
    output out_r, out_g, out_b, out_sof, out_eol, out_eof
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    output out_ready,
    input  out_r, out_g, out_b, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/frame_pixel_sequencer.sv
// Frame pixel sequencer.
// Reads one grayscale frame linearly out of frame memory (fixed 1-cycle read latency),
// buffers returned pixels in a small FIFO and streams them as RGB with valid/ready
// backpressure and sof/eol/eof framing.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a frame (only honoured in idle)
//   abort    : synchronous cancel of the running frame
//   busy     : high while fetching or draining
//   done     : one-cycle pulse after the eof pixel is accepted
//   px_bus   : memory read port and pixel output stream (master side)
module frame_pixel_sequencer #(
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  frame_pixel_sequencer_if.master px_bus
);

  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned ColW   = $clog2(IMG_W);
  localparam int unsigned RowW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ColW-1:0]   col_t;
  typedef logic [RowW-1:0]   row_t;
  typedef logic [PtrW-1:0]   ptr_t;
  typedef logic [CntW-1:0]   cnt_t;
  typedef logic [PIX_W-1:0]  pix_t;

  localparam addr_t LastAddr = addr_t'(NumPix - 1);
  localparam col_t  LastCol  = col_t'(IMG_W - 1);
  localparam row_t  LastRow  = row_t'(IMG_H - 1);
  localparam ptr_t  LastPtr  = ptr_t'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e state_q, state_d;

  addr_t rd_addr_q;
  logic  inflight_q;
  pix_t  fifo_mem [FIFO_DEPTH];
  ptr_t  wr_ptr_q, rd_ptr_q;
  cnt_t  fifo_cnt_q;
  col_t  col_q;
  row_t  row_q;

  logic active, rd_en, last_issue, valid_int, xfer, push, clr, at_eol, at_eof;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    active     = (state_q == StFetch) || (state_q == StDrain);
    // In-flight read already owns a FIFO slot, so it counts against the free space.
    rd_en      = (state_q == StFetch) &&
                 ((int'(fifo_cnt_q) + int'(inflight_q)) < FIFO_DEPTH);
    last_issue = rd_en && (rd_addr_q == LastAddr);
    valid_int  = active && (fifo_cnt_q != '0);
    // abort wins over a same-cycle handshake: nothing is consumed.
    xfer       = valid_int && px_bus.out_ready && !abort;
    push       = inflight_q && !abort;
    clr        = abort || !active;
    at_eol     = (col_q == LastCol);
    at_eof     = at_eol && (row_q == LastRow);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !abort) state_d = StFetch;
      StFetch: begin
        if (abort)           state_d = StIdle;
        else if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (abort)               state_d = StIdle;
        else if (xfer && at_eof) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; data and flags are gated so everything reads 0 when not valid.
  always_comb begin
    busy               = active;
    done               = (state_q == StDone);
    px_bus.mem_rd_en   = rd_en;
    px_bus.mem_rd_addr = rd_addr_q;
    px_bus.out_valid   = valid_int;
    px_bus.out_r       = valid_int ? fifo_mem[rd_ptr_q] : '0;
    px_bus.out_g       = px_bus.out_r;
    px_bus.out_b       = px_bus.out_r;
    px_bus.out_sof     = valid_int && (row_q == '0) && (col_q == '0);
    px_bus.out_eol     = valid_int && at_eol;
    px_bus.out_eof     = valid_int && at_eof;
  end

  // Read address, in-flight flag, FIFO control and output-side framing counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else if (clr) begin
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) rd_addr_q <= rd_addr_q + addr_t'(1);
      if (push)  wr_ptr_q  <= ptr_inc(wr_ptr_q);
      if (xfer)  rd_ptr_q  <= ptr_inc(rd_ptr_q);
      unique case ({push, xfer})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + cnt_t'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - cnt_t'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (xfer) begin
        if (at_eol) begin
          col_q <= '0;
          row_q <= at_eof ? '0 : row_q + row_t'(1);
        end else begin
          col_q <= col_q + col_t'(1);
        end
      end
    end
  end

  // FIFO storage needs no reset: contents are only visible while valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= px_bus.mem_rd_data;
  end

endmodule

// File: tb/tb_frame_pixel_sequencer.sv
// Self-checking bench for frame_pixel_sequencer on a 4x3 frame with mem[a] = a.
module tb_frame_pixel_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int p;
  int dones;

  frame_pixel_sequencer_if #(.ADDR_W(8), .PIX_W(8)) pbus ();

  frame_pixel_sequencer #(
    .IMG_W(4), .IMG_H(3), .ADDR_W(8), .PIX_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .px_bus(pbus)
  );

  always #5 clk = ~clk;

  // Frame memory model: mem[a] = a, one cycle read latency.
  always @(posedge clk) begin
    pbus.mem_rd_data <= pbus.mem_rd_en ? pbus.mem_rd_addr : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from a start pulse in cycle 0; checks order, flags, stability and done.
  task automatic run_frame(input int stall_lo, input int stall_hi, input int extra_start,
                           input bit chk_rd, input string tag);
    int idx = 0;
    int nd = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_r = '0;
    logic [2:0] prev_flags = '0;
    start = 1'b1;
    pbus.out_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      start = (c == extra_start);
      pbus.out_ready = !(c >= stall_lo && c <= stall_hi);
      if (done) nd++;
      if (prev_stall) begin
        check({tag, " hold valid"}, 32'(pbus.out_valid), 32'd1);
        check({tag, " hold data"}, 32'(pbus.out_r), 32'(prev_r));
        check({tag, " hold flags"}, 32'({pbus.out_sof, pbus.out_eol, pbus.out_eof}),
              32'(prev_flags));
      end
      if (chk_rd && c == 6) begin
        check({tag, " rd_en@6"}, 32'(pbus.mem_rd_en), 32'd1);
        check({tag, " addr@6"}, 32'(pbus.mem_rd_addr), 32'd5);
      end
      if (chk_rd && (c == 7 || c == 10)) check({tag, " rd stall"}, 32'(pbus.mem_rd_en), 32'd0);
      if (chk_rd && c == 11) begin
        check({tag, " rd_en@11"}, 32'(pbus.mem_rd_en), 32'd1);
        check({tag, " addr@11"}, 32'(pbus.mem_rd_addr), 32'd6);
      end
      if (pbus.out_valid && pbus.out_ready) begin
        check({tag, " r"}, 32'(pbus.out_r), 32'(idx));
        check({tag, " g"}, 32'(pbus.out_g), 32'(idx));
        check({tag, " b"}, 32'(pbus.out_b), 32'(idx));
        check({tag, " sof"}, 32'(pbus.out_sof), 32'(idx == 0));
        check({tag, " eol"}, 32'(pbus.out_eol), 32'(idx % 4 == 3));
        check({tag, " eof"}, 32'(pbus.out_eof), 32'(idx == 11));
        idx++;
      end
      prev_stall = pbus.out_valid && !pbus.out_ready;
      prev_r     = pbus.out_r;
      prev_flags = {pbus.out_sof, pbus.out_eol, pbus.out_eof};
    end
    check({tag, " pixel count"}, 32'(idx), 32'd12);
    check({tag, " done count"}, 32'(nd), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    pbus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #3;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rd_en", 32'(pbus.mem_rd_en), 32'd0);
    check("rst addr", 32'(pbus.mem_rd_addr), 32'd0);
    check("rst valid", 32'(pbus.out_valid), 32'd0);
    check("rst flags", 32'({pbus.out_sof, pbus.out_eol, pbus.out_eof}), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Cycle-exact frame with ready held high.
    start = 1'b1;
    pbus.out_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      start = 1'b0;
      if (c == 1) begin
        check("t1 rd_en@1", 32'(pbus.mem_rd_en), 32'd1);
        check("t1 addr@1", 32'(pbus.mem_rd_addr), 32'd0);
        check("t1 busy@1", 32'(busy), 32'd1);
      end
      if (c <= 2) check("t1 early valid", 32'(pbus.out_valid), 32'd0);
      if (c >= 3 && c <= 14) begin
        p = c - 3;
        check("t1 valid", 32'(pbus.out_valid), 32'd1);
        check("t1 r", 32'(pbus.out_r), 32'(p));
        check("t1 g", 32'(pbus.out_g), 32'(p));
        check("t1 b", 32'(pbus.out_b), 32'(p));
        check("t1 sof", 32'(pbus.out_sof), 32'(p == 0));
        check("t1 eol", 32'(pbus.out_eol), 32'(p % 4 == 3));
        check("t1 eof", 32'(pbus.out_eof), 32'(p == 11));
        check("t1 done low", 32'(done), 32'd0);
      end
      if (c == 13) check("t1 drain rd_en", 32'(pbus.mem_rd_en), 32'd0);
      if (c == 15) begin
        check("t1 done@15", 32'(done), 32'd1);
        check("t1 valid@15", 32'(pbus.out_valid), 32'd0);
        check("t1 busy@15", 32'(busy), 32'd0);
        check("t1 rd_en@15", 32'(pbus.mem_rd_en), 32'd0);
      end
      if (c == 16) check("t1 done@16", 32'(done), 32'd0);
    end

    // Backpressure: ready low in cycles 5..9.
    run_frame(5, 9, 0, 1'b1, "bp");

    // Abort after pixel 5, then restart.
    start = 1'b1;
    pbus.out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start = 1'b0;
    end
    check("ab px5", 32'(pbus.out_r), 32'd5);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab busy", 32'(busy), 32'd0);
    check("ab valid", 32'(pbus.out_valid), 32'd0);
    check("ab rd_en", 32'(pbus.mem_rd_en), 32'd0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) dones++;
      step();
    end
    check("ab no done", 32'(dones), 32'd0);
    run_frame(0, -1, 0, 1'b0, "restart");

    // Async reset mid-drain.
    start = 1'b1;
    pbus.out_ready = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      start = 1'b0;
    end
    check("ar pre busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar busy", 32'(busy), 32'd0);
    check("ar valid", 32'(pbus.out_valid), 32'd0);
    check("ar data", 32'(pbus.out_r), 32'd0);
    check("ar flags", 32'({pbus.out_sof, pbus.out_eol, pbus.out_eof}), 32'd0);
    check("ar rd_en", 32'(pbus.mem_rd_en), 32'd0);
    check("ar addr", 32'(pbus.mem_rd_addr), 32'd0);
    check("ar done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Start pulsed again while busy must not produce a second frame.
    run_frame(0, -1, 5, 1'b0, "dblstart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
